spi_config_arbiter: RTL and testbench

- Shares one SPI master channel (mode 0, MSB first) between two requesters, e.g. the sensor configurator and a run-time register access path.
- Round-robin arbitration; one word per grant; per-requester read-back data and a completion pulse.
- Drives the two-slave SPI bus (sclk, mosi, miso, ss_n[1:0]) of the image-sensor board.
- Replaces direct SPI pin ownership by any single requester.

---
 rtl/spi_config_arbiter_pkg.sv | 22 ++
 rtl/spi_word_shifter.sv | 78 +++++++
 rtl/spi_config_arbiter.sv | 139 +++++++++++++
 tb/tb_spi_config_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_config_arbiter_pkg.sv
// Shared types and defaults for the two-requester SPI configuration arbiter.
package spi_config_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  localparam int DEFAULT_CLK_DIV    = 4;
  localparam int DEFAULT_WORD_WIDTH = 16;

  // Counter width for a modulo-n count; never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// Mode-0 MSB-first word engine: a CLK_DIV lead-in with sclk low, then
// WORD_WIDTH sclk periods (high half, low half), finished on the last cycle.
module spi_word_shifter
  import spi_config_arbiter_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] tx_word,
  input  logic                  miso,
  output logic [WORD_WIDTH-1:0] rx_word,
  output logic                  finished,
  output logic                  sclk,
  output logic                  mosi
);

  localparam int DIV_W  = cnt_width(CLK_DIV);
  localparam int HALF_W = cnt_width(2 * WORD_WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * WORD_WIDTH);

  logic                  active;
  logic                  sclk_q;
  logic [DIV_W-1:0]      div_cnt;
  logic [HALF_W-1:0]     half_idx;
  logic [HALF_W-1:0]     half_nxt;
  logic                  half_end;
  logic [WORD_WIDTH-1:0] tx_sr;
  logic [WORD_WIDTH-1:0] rx_sr;

  // half_idx 0 is the lead-in; odd halves are sclk high, even halves low.
  assign half_end = active && (div_cnt == DIV_LAST);
  assign half_nxt = half_idx + 1'b1;
  assign finished = half_end && (half_idx == HALF_LAST);
  assign rx_word  = rx_sr;
  assign sclk     = sclk_q;
  assign mosi     = tx_sr[WORD_WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= 1'b0;
      sclk_q   <= 1'b0;
      div_cnt  <= '0;
      half_idx <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else if (start) begin
      active   <= 1'b1;
      sclk_q   <= 1'b0;
      div_cnt  <= '0;
      half_idx <= '0;
      tx_sr    <= tx_word;
      rx_sr    <= '0;
    end else if (finished) begin
      active   <= 1'b0;
      sclk_q   <= 1'b0;
      div_cnt  <= '0;
      half_idx <= '0;
      tx_sr    <= '0;
    end else if (half_end) begin
      div_cnt  <= '0;
      half_idx <= half_nxt;
      sclk_q   <= half_nxt[0];
      if (half_nxt[0]) begin
        rx_sr <= {rx_sr[WORD_WIDTH-2:0], miso};
      end else if (half_nxt != HALF_LAST) begin
        // the final fall leaves the LSB on mosi
        tx_sr <= {tx_sr[WORD_WIDTH-2:0], 1'b0};
      end
    end else if (active) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_config_arbiter.sv
// Round-robin owner of one SPI master channel shared by two requesters;
// one word per grant, per-requester read-back and completion pulse.
module spi_config_arbiter
  import spi_config_arbiter_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int NUM_SLAVES = 2,
  parameter int SS_IDX_W   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [WORD_WIDTH-1:0] req0_data,
  input  logic [SS_IDX_W-1:0]   req0_slave,
  output logic [WORD_WIDTH-1:0] req0_rdata,
  output logic                  req0_done,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [WORD_WIDTH-1:0] req1_data,
  input  logic [SS_IDX_W-1:0]   req1_slave,
  output logic [WORD_WIDTH-1:0] req1_rdata,
  output logic                  req1_done,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SLAVES-1:0] ss_n,
  output logic                  busy,
  output logic [1:0]            grant,
  output state_t                dbg_state
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Handshake: a word moves on the rising edge where reqN_valid && reqN_ready;
  // ready is offered only in IDLE and only to the arbitration winner.
  state_t                state, state_nxt;
  logic [DIV_W-1:0]      cnt;
  logic                  cnt_last;
  logic                  prio1;
  logic [1:0]            grant_q;
  logic [SS_IDX_W-1:0]   slave_q, slave_nxt;
  logic [NUM_SLAVES-1:0] ss_n_q, ss_dec;
  logic                  win0, win1, accept;
  logic [WORD_WIDTH-1:0] tx_word, rx_word;
  logic                  finished;
  logic                  done0_q, done1_q;
  logic [WORD_WIDTH-1:0] rdata0_q, rdata1_q;

  // prio1 set means requester 1 wins a tie (requester 0 was served last).
  assign win0       = req0_valid && (!req1_valid || !prio1);
  assign win1       = req1_valid && (!req0_valid || prio1);
  assign req0_ready = (state == IDLE) && !reset && win0;
  assign req1_ready = (state == IDLE) && !reset && win1;
  assign accept     = req0_ready || req1_ready;
  assign tx_word    = req1_ready ? req1_data : req0_data;
  assign slave_nxt  = !accept ? slave_q : (req1_ready ? req1_slave : req0_slave);
  assign cnt_last   = (cnt == DIV_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SETUP;
      SETUP:   if (cnt_last) state_nxt = SHIFT;
      SHIFT:   if (finished) state_nxt = GAP;
      GAP:     if (cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range slave indices match no line, so the word runs unselected.
  always_comb begin
    ss_dec = '1;
    if (state_nxt == SETUP || state_nxt == SHIFT) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (int'(slave_nxt) == i) ss_dec[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prio1    <= 1'b0;
      grant_q  <= '0;
      slave_q  <= '0;
      ss_n_q   <= '1;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state   <= state_nxt;
      ss_n_q  <= ss_dec;
      slave_q <= slave_nxt;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (state_nxt != state || state == IDLE || state == SHIFT) cnt <= '0;
      else                                                       cnt <= cnt + 1'b1;
      if (accept) grant_q <= req1_ready ? 2'b10 : 2'b01;
      if (state == SHIFT && finished) begin
        done0_q <= grant_q[REQ0];
        done1_q <= grant_q[REQ1];
        if (grant_q[REQ0]) rdata0_q <= rx_word;
        if (grant_q[REQ1]) rdata1_q <= rx_word;
        prio1   <= grant_q[REQ0];
      end
      if (state == GAP && cnt_last) grant_q <= '0;
    end
  end

  spi_word_shifter #(
    .CLK_DIV    (CLK_DIV),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .start    (accept),
    .tx_word  (tx_word),
    .miso     (miso),
    .rx_word  (rx_word),
    .finished (finished),
    .sclk     (sclk),
    .mosi     (mosi)
  );

  assign ss_n       = ss_n_q;
  assign busy       = (state != IDLE);
  assign grant      = grant_q;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_spi_config_arbiter.sv
// Bench for spi_config_arbiter: default build against a mode-0 slave model,
// plus a CLK_DIV=1 build with mosi looped back to miso.
module tb_spi_config_arbiter;
  import spi_config_arbiter_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- default-build DUT ----------------
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_slave = 1'b0, req1_slave = 1'b0;
  logic [W-1:0] req0_rdata, req1_rdata;
  logic         req0_done, req1_done;
  logic         sclk, mosi, miso;
  logic [1:0]   ss_n, grant;
  logic         busy;
  state_t       dbg_state;

  spi_config_arbiter u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_slave(req0_slave), .req0_rdata(req0_rdata), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_slave(req1_slave), .req1_rdata(req1_rdata), .req1_done(req1_done),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n),
    .busy(busy), .grant(grant), .dbg_state(dbg_state)
  );

  // ---------------- CLK_DIV=1 DUT ----------------
  logic         f_req0_valid = 1'b0, f_req1_valid = 1'b0;
  logic         f_req0_ready, f_req1_ready;
  logic [W-1:0] f_req0_data = '0, f_req1_data = '0;
  logic         f_req0_slave = 1'b0, f_req1_slave = 1'b0;
  logic [W-1:0] f_req0_rdata, f_req1_rdata;
  logic         f_req0_done, f_req1_done;
  logic         f_sclk, f_mosi, f_miso;
  logic [1:0]   f_ss_n, f_grant;
  logic         f_busy;
  state_t       f_dbg_state;

  assign f_miso = f_mosi;

  spi_config_arbiter #(.CLK_DIV(1)) u_dut_fast (
    .clk(clk), .reset(reset),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_data(f_req0_data),
    .req0_slave(f_req0_slave), .req0_rdata(f_req0_rdata), .req0_done(f_req0_done),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_data(f_req1_data),
    .req1_slave(f_req1_slave), .req1_rdata(f_req1_rdata), .req1_done(f_req1_done),
    .sclk(f_sclk), .mosi(f_mosi), .miso(f_miso), .ss_n(f_ss_n),
    .busy(f_busy), .grant(f_grant), .dbg_state(f_dbg_state)
  );

  // ---------------- slave model and bus monitor ----------------
  logic         mon_clr = 1'b0;
  logic [W-1:0] sl_word = '0;
  int           sl_cnt = 0;
  logic         sclk_prev = 1'b0;
  logic [W-1:0] mosi_cap = '0;
  int           ss_low_cnt = 0;
  logic [1:0]   ss_pat = 2'b11;
  int           done_cnt0 = 0, done_cnt1 = 0, done_bad = 0;

  // Mode-0 slave: MSB presented at select, next bit after each sclk fall.
  assign miso = (sl_cnt < W) ? sl_word[W-1-sl_cnt] : 1'b0;

  always @(negedge clk) begin
    if (!busy) sl_cnt = 0;
    else if (sclk_prev && !sclk) sl_cnt++;
    if (mon_clr) begin
      mosi_cap = '0; ss_low_cnt = 0; ss_pat = 2'b11;
      done_cnt0 = 0; done_cnt1 = 0; done_bad = 0;
    end else begin
      if (!sclk_prev && sclk) mosi_cap = {mosi_cap[W-2:0], mosi};
      if (ss_n != 2'b11) begin ss_low_cnt++; ss_pat = ss_n; end
      if (req0_done) begin done_cnt0++; if (grant != 2'b01) done_bad++; end
      if (req1_done) begin done_cnt1++; if (grant != 2'b10) done_bad++; end
    end
    sclk_prev = sclk;
  end

  // ---------------- reference model state ----------------
  int           last_served = 1;
  logic [W-1:0] exp_rd [2] = '{16'h0, 16'h0};

  typedef struct {
    logic         v0, v1;
    logic [W-1:0] d0, d1;
    logic         s0, s1;
    logic [W-1:0] sw;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 400) begin tick(); t++; end
    check(name, 32'(busy), 0);
  endtask

  task automatic model_reset();
    last_served = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int           w, t;
    logic [W-1:0] d;
    logic         s;
    logic [1:0]   exp_ss;
    w = (v.v0 && v.v1) ? ((last_served == 0) ? 1 : 0) : (v.v0 ? 0 : 1);
    d = (w == 0) ? v.d0 : v.d1;
    s = (w == 0) ? v.s0 : v.s1;
    exp_ss = 2'b11;
    exp_ss[s] = 1'b0;
    sl_word = v.sw;
    clear_mon();
    req0_valid = v.v0; req0_data = v.d0; req0_slave = v.s0;
    req1_valid = v.v1; req1_data = v.d1; req1_slave = v.s1;
    #1;
    check("ready_winner", {30'b0, req1_ready, req0_ready}, (w == 0) ? 32'd1 : 32'd2);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    t = 0;
    while (!(req0_done || req1_done) && t < 400) begin tick(); t++; end
    check("done_seen", 32'(t < 400), 1);
    exp_rd[w] = v.sw;
    check("rdata0", req0_rdata, exp_rd[0]);
    check("rdata1", req1_rdata, exp_rd[1]);
    wait_idle("vec_idle");
    check("mosi_bits", mosi_cap, d);
    check("ss_low_cycles", ss_low_cnt, 132);
    check("ss_select", ss_pat, exp_ss);
    check("done_counts", done_cnt0 * 16 + done_cnt1, (w == 0) ? 32'd16 : 32'd1);
    check("done_owner", done_bad, 0);
    last_served = w;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int           owners[$];
    int           acc_t[$];
    logic [1:0]   gq[$];
    logic [1:0]   gprev;
    int           edges, bcnt, n_acc, tg, ssl;
    int           c_acc[2];
    logic         sp, fp;
    logic [W-1:0] frd[$];
    vec_t         v;

    repeat (3) tick();
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_ss_n", ss_n, 2'b11);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    check("rst_done", {req1_done, req0_done}, 0);
    check("rst_rdata0", req0_rdata, 0);
    check("rst_rdata1", req1_rdata, 0);
    check("rst_busy_grant", {busy, grant}, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    model_reset();
    tick();

    // Both requesters valid from the first cycle, held for four transfers.
    sl_word = 16'h1234;
    clear_mon();
    req0_valid = 1'b1; req0_data = 16'h1111; req0_slave = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h2222; req1_slave = 1'b1;
    gprev = 2'b00;
    #1;
    for (int c = 0; c < 800 && owners.size() < 4; c++) begin
      if (req0_ready) begin owners.push_back(0); acc_t.push_back(c); end
      else if (req1_ready) begin owners.push_back(1); acc_t.push_back(c); end
      tick();
      if (grant != gprev) begin gq.push_back(grant); gprev = grant; end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("rr_idle");
    check("rr_accepts", owners.size(), 4);
    for (int i = 0; i < 4; i++)
      check("rr_owner", (i < owners.size()) ? owners[i] : -1, i % 2);
    check("grant_seq0", (gq.size() > 0) ? gq[0] : 2'bxx, 2'b01);
    check("grant_seq1", (gq.size() > 1) ? gq[1] : 2'bxx, 2'b00);
    check("grant_seq2", (gq.size() > 2) ? gq[2] : 2'bxx, 2'b10);
    check("accept_spacing", (acc_t.size() > 1) ? acc_t[1] - acc_t[0] : -1, 137);
    check("rr_done0", done_cnt0, 2);
    check("rr_done1", done_cnt1, 2);
    check("rr_done_owner", done_bad, 0);
    check("rr_ss_low", ss_low_cnt, 4 * 132);
    last_served = 1;
    exp_rd[0] = 16'h1234;
    exp_rd[1] = 16'h1234;
    check("rr_rdata0", req0_rdata, exp_rd[0]);
    check("rr_rdata1", req1_rdata, exp_rd[1]);

    // Table of directed vectors followed by randomized ones.
    vecs.push_back('{1'b1, 1'b0, 16'hA55A, 16'h0000, 1'b1, 1'b0, 16'h3C96});
    vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF});
    vecs.push_back('{1'b1, 1'b1, 16'h8001, 16'h7FFE, 1'b0, 1'b1, 16'hC3C3});
    vecs.push_back('{1'b1, 1'b1, 16'h1357, 16'h2468, 1'b1, 1'b0, 16'h0F0F});
    vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h0000});
    for (int i = 0; i < 10; i++) begin
      v.v0 = 1'($urandom_range(0, 1));
      v.v1 = 1'($urandom_range(0, 1));
      if (!v.v0 && !v.v1) v.v0 = 1'b1;
      v.d0 = 16'($urandom_range(0, 65535));
      v.d1 = 16'($urandom_range(0, 65535));
      v.s0 = 1'($urandom_range(0, 1));
      v.s1 = 1'($urandom_range(0, 1));
      v.sw = 16'($urandom_range(0, 65535));
      vecs.push_back(v);
    end
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset at the fifth sclk edge of a requester 1 transfer.
    sl_word = 16'hBEEF;
    clear_mon();
    req1_valid = 1'b1; req1_data = 16'h5AA5; req1_slave = 1'b0;
    #1;
    tick();
    req1_valid = 1'b0;
    edges = 0;
    sp = sclk;
    for (int c = 0; c < 300 && edges < 5; c++) begin
      tick();
      if (sclk != sp) begin edges++; sp = sclk; end
    end
    check("abort_edges", edges, 5);
    reset = 1'b1;
    tick();
    check("abort_ss_n", ss_n, 2'b11);
    check("abort_sclk", 32'(sclk), 0);
    check("abort_busy", 32'(busy), 0);
    reset = 1'b0;
    model_reset();
    repeat (150) tick();
    check("abort_no_done", done_cnt1, 0);
    check("abort_rdata1", req1_rdata, exp_rd[1]);
    run_vec('{1'b0, 1'b1, 16'h0000, 16'h5AA5, 1'b0, 1'b0, 16'hBEEF});

    // Requester 0 pulses valid for one cycle while requester 1 owns the bus.
    sl_word = 16'h6B2D;
    clear_mon();
    req1_valid = 1'b1; req1_data = 16'h0F1E; req1_slave = 1'b1;
    #1;
    tick();
    req1_valid = 1'b0;
    repeat (10) tick();
    req0_valid = 1'b1; req0_data = 16'hDEAD; req0_slave = 1'b0;
    #1;
    check("drop_ready", 32'(req0_ready), 0);
    tick();
    req0_valid = 1'b0;
    wait_idle("drop_idle");
    bcnt = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (busy) bcnt++;
    end
    check("drop_no_transfer", bcnt, 0);
    check("drop_done0", done_cnt0, 0);
    exp_rd[1] = 16'h6B2D;
    last_served = 1;
    check("drop_rdata1", req1_rdata, exp_rd[1]);
    check("drop_rdata0", req0_rdata, exp_rd[0]);

    // CLK_DIV=1 build: back-to-back words from requester 1, mosi looped to miso.
    f_req1_valid = 1'b1; f_req1_data = 16'hFFFF; f_req1_slave = 1'b0;
    #1;
    n_acc = 0; tg = 0; ssl = 0;
    c_acc[0] = 0; c_acc[1] = 0;
    fp = f_sclk;
    for (int c = 0; c < 200; c++) begin
      logic a;
      a = f_req1_ready;
      tick();
      if (f_sclk != fp) tg++;
      fp = f_sclk;
      if (f_ss_n != 2'b11) ssl++;
      if (f_req1_done) frd.push_back(f_req1_rdata);
      if (f_req0_done) check("fast_done0", 32'(f_req0_done), 0);
      if (a) begin
        if (n_acc < 2) c_acc[n_acc] = c;
        n_acc++;
        if (n_acc == 1) f_req1_data = 16'h0001;
        else f_req1_valid = 1'b0;
      end
    end
    check("fast_accepts", n_acc, 2);
    check("fast_spacing", c_acc[1] - c_acc[0], 35);
    check("fast_sclk_toggles", tg, 64);
    check("fast_ss_low", ssl, 66);
    check("fast_dones", frd.size(), 2);
    check("fast_rdata_a", (frd.size() > 0) ? frd[0] : 16'hxxxx, 16'hFFFF);
    check("fast_rdata_b", (frd.size() > 1) ? frd[1] : 16'hxxxx, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
